// File: rtl/lcd_hd44780_timed_ctrl.sv
// lcd_hd44780_timed_ctrl: Avalon-MM slave driving an HD44780 character LCD
// with timed RS/RW setup, E pulse width and hold, in 8-bit or 4-bit bus mode.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   address[1:0]       [0] = LCD RW, [1] = LCD RS
//   read, write        Avalon requests (write wins if both asserted)
//   writedata[7:0]     byte to send to the LCD
//   readdata[7:0]      byte read from the LCD, valid while waitrequest is low
//   waitrequest        Avalon stall, low only in the DONE cycle
//   LCD_E/RS/RW        registered LCD control lines
//   LCD_data[7:0]      bidirectional LCD bus, driven only during write phases
module lcd_hd44780_timed_ctrl #(
    parameter int SETUP_CYCLES  = 2,
    parameter int E_HIGH_CYCLES = 12,
    parameter int HOLD_CYCLES   = 2,
    parameter int BUS_4BIT      = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] address,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       waitrequest,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    inout  wire  [7:0] LCD_data
);

    localparam int MAX_SP = (SETUP_CYCLES > E_HIGH_CYCLES) ?
                            SETUP_CYCLES : E_HIGH_CYCLES;
    localparam int MAXC   = (MAX_SP > HOLD_CYCLES) ? MAX_SP : HOLD_CYCLES;
    localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] E_LD     = CW'(E_HIGH_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        DONE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          nib;
    logic          nib_n;
    logic [7:0]    wd;
    logic          accept;
    logic          legal;
    logic          sample;
    logic          bus_drive;
    logic [7:0]    dout;

    // Write wins; an access is legal only if the RW bit matches direction.
    assign legal = write ? ~address[0] : address[0];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        nib_n   = nib;
        accept  = 1'b0;
        sample  = 1'b0;
        unique case (state)
            IDLE: begin
                if (read | write) begin
                    accept = 1'b1;
                    if (legal) begin
                        state_n = SETUP;
                        cnt_n   = SETUP_LD;
                        nib_n   = 1'b0;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_n = PULSE;
                    cnt_n   = E_LD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_n = HOLD;
                    cnt_n   = HOLD_LD;
                    sample  = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    if ((BUS_4BIT != 0) && !nib) begin
                        state_n = SETUP;
                        cnt_n   = SETUP_LD;
                        nib_n   = 1'b1;
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            nib      <= 1'b0;
            wd       <= 8'h00;
            readdata <= 8'h00;
            LCD_E    <= 1'b0;
            LCD_RS   <= 1'b0;
            LCD_RW   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            nib   <= nib_n;
            // E is a register that mirrors the PULSE state exactly.
            LCD_E <= (state_n == PULSE);
            if (accept && legal) begin
                LCD_RS <= address[1];
                LCD_RW <= ~write;
                wd     <= writedata;
            end
            // Any accepted read (legal or not) starts from a clean zero.
            if (accept && !write) begin
                readdata <= 8'h00;
            end
            if (sample && LCD_RW) begin
                if (BUS_4BIT != 0) begin
                    if (nib) begin
                        readdata[3:0] <= LCD_data[7:4];
                    end else begin
                        readdata[7:4] <= LCD_data[7:4];
                    end
                end else begin
                    readdata <= LCD_data;
                end
            end
        end
    end

    assign waitrequest = (read | write) & (state != DONE);

    assign bus_drive = ~LCD_RW &
                       ((state == SETUP) | (state == PULSE) |
                        (state == HOLD));

    assign dout = (BUS_4BIT != 0) ?
                  {(nib ? wd[3:0] : wd[7:4]), 4'h0} : wd;

    assign LCD_data = bus_drive ? dout : 8'bz;

endmodule

// File: tb/tb_lcd_hd44780_timed_ctrl.sv
// tb_lcd_hd44780_timed_ctrl: directed bench for the timed HD44780 controller,
// one 8-bit instance and one 4-bit instance with default timing.
module tb_lcd_hd44780_timed_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] addr_i;
    logic [7:0] wd_i;
    logic       rd_i;
    logic       wr_i;
    bit         sel;
    bit         rd_mode;
    logic [7:0] drv_val;

    logic [7:0] rdata8, rdata4;
    logic       wait8, wait4;
    logic       e8, e4, rs8, rs4, rw8, rw4;
    wire  [7:0] bus8, bus4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign bus8 = (!sel && rd_mode && e8) ? drv_val : 8'bz;
    assign bus4 = (sel && rd_mode && e4) ? drv_val : 8'bz;

    lcd_hd44780_timed_ctrl dut8 (
        .clk        (clk),
        .reset      (reset),
        .address    (addr_i),
        .read       (rd_i & !sel),
        .write      (wr_i & !sel),
        .writedata  (wd_i),
        .readdata   (rdata8),
        .waitrequest(wait8),
        .LCD_E      (e8),
        .LCD_RS     (rs8),
        .LCD_RW     (rw8),
        .LCD_data   (bus8)
    );

    lcd_hd44780_timed_ctrl #(.BUS_4BIT(1)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .address    (addr_i),
        .read       (rd_i & sel),
        .write      (wr_i & sel),
        .writedata  (wd_i),
        .readdata   (rdata4),
        .waitrequest(wait4),
        .LCD_E      (e4),
        .LCD_RS     (rs4),
        .LCD_RW     (rw4),
        .LCD_data   (bus4)
    );

    logic       cur_e, cur_wait, cur_rs, cur_rw, cur_drive;
    logic [7:0] cur_bus, cur_rdata;

    assign cur_e     = sel ? e4 : e8;
    assign cur_wait  = sel ? wait4 : wait8;
    assign cur_rs    = sel ? rs4 : rs8;
    assign cur_rw    = sel ? rw4 : rw8;
    assign cur_bus   = sel ? bus4 : bus8;
    assign cur_rdata = sel ? rdata4 : rdata8;
    assign cur_drive = sel ? dut4.bus_drive : dut8.bus_drive;

    int         r_done, r_efirst, r_ecyc, r_epul, r_drv, r_bad, r_badrs;
    logic [7:0] r_rdata;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One Avalon transfer on the selected instance; collects per-cycle
    // observations into the r_* summary variables.
    task automatic xfer(input bit four, input bit wr, input logic [1:0] addr,
                        input logic [7:0] wd, input logic [7:0] rb);
        logic       prev_e;
        logic [7:0] exp;
        sel      = four;
        rd_mode  = !wr;
        addr_i   = addr;
        wd_i     = wd;
        drv_val  = 8'h00;
        r_done   = -1;
        r_efirst = -1;
        r_ecyc   = 0;
        r_epul   = 0;
        r_drv    = 0;
        r_bad    = 0;
        r_badrs  = 0;
        r_rdata  = 8'h00;
        prev_e   = 1'b0;
        rd_i     = !wr;
        wr_i     = wr;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (four) begin
                drv_val = (c <= 16) ? {rb[7:4], 4'h0} : {rb[3:0], 4'h0};
                exp     = (c <= 16) ? {wd[7:4], 4'h0} : {wd[3:0], 4'h0};
            end else begin
                drv_val = rb;
                exp     = wd;
            end
            if (cur_e) begin
                r_ecyc++;
                if (!prev_e) begin
                    r_epul++;
                    if (r_efirst < 0) r_efirst = c;
                end
            end
            prev_e = cur_e;
            if (cur_drive) begin
                r_drv++;
                if (cur_bus !== exp) r_bad++;
            end
            if (c >= 1 && (cur_rs !== addr[1] || cur_rw !== !wr)) r_badrs++;
            if (!cur_wait) begin
                r_done  = c;
                r_rdata = cur_rdata;
                break;
            end
        end
        @(posedge clk);
        #1;
        rd_i    = 1'b0;
        wr_i    = 1'b0;
        rd_mode = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        rd_i    = 1'b0;
        wr_i    = 1'b0;
        addr_i  = 2'b00;
        wd_i    = 8'h00;
        sel     = 1'b0;
        rd_mode = 1'b0;
        drv_val = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_e", {31'd0, e8}, 32'd0);
        check("rst_rs", {31'd0, rs8}, 32'd0);
        check("rst_rw", {31'd0, rw8}, 32'd0);
        check("rst_rdata", {24'd0, rdata8}, 32'd0);
        check("rst_drive", {31'd0, dut8.bus_drive}, 32'd0);
        check("rst_wait", {31'd0, wait8}, 32'd0);
        check("rst_e4", {31'd0, e4}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 8-bit command write 0x38
        xfer(1'b0, 1'b1, 2'b00, 8'h38, 8'h00);
        check("w8_done", r_done, 17);
        check("w8_efirst", r_efirst, 3);
        check("w8_ecyc", r_ecyc, 12);
        check("w8_epul", r_epul, 1);
        check("w8_drv", r_drv, 16);
        check("w8_data", r_bad, 0);
        check("w8_rsrw", r_badrs, 0);

        // 8-bit status read returning 0x80
        xfer(1'b0, 1'b0, 2'b01, 8'h00, 8'h80);
        check("r8_done", r_done, 17);
        check("r8_rdata", {24'd0, r_rdata}, 32'h80);
        check("r8_drv", r_drv, 0);
        check("r8_ecyc", r_ecyc, 12);
        check("r8_rsrw", r_badrs, 0);

        // illegal write to address 01
        xfer(1'b0, 1'b1, 2'b01, 8'hFF, 8'h00);
        check("iw_done", r_done, 1);
        check("iw_epul", r_epul, 0);
        check("iw_drv", r_drv, 0);

        // illegal read of address 10 clears the stale 0x80
        xfer(1'b0, 1'b0, 2'b10, 8'h00, 8'h00);
        check("ir_done", r_done, 1);
        check("ir_rdata", {24'd0, r_rdata}, 32'h0);
        check("ir_epul", r_epul, 0);

        // 4-bit data write 0xA5
        xfer(1'b1, 1'b1, 2'b10, 8'hA5, 8'h00);
        check("w4_done", r_done, 33);
        check("w4_epul", r_epul, 2);
        check("w4_ecyc", r_ecyc, 24);
        check("w4_drv", r_drv, 32);
        check("w4_data", r_bad, 0);
        check("w4_rsrw", r_badrs, 0);

        // 4-bit data read, nibbles 0x4 then 0x1
        xfer(1'b1, 1'b0, 2'b11, 8'h00, 8'h41);
        check("r4_done", r_done, 33);
        check("r4_rdata", {24'd0, r_rdata}, 32'h41);
        check("r4_drv", r_drv, 0);
        check("r4_epul", r_epul, 2);

        // reset during PULSE, then a normal write
        sel    = 1'b0;
        addr_i = 2'b10;
        wd_i   = 8'h55;
        wr_i   = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("mr_e_before", {31'd0, e8}, 32'd1);
        reset = 1'b1;
        wr_i  = 1'b0;
        @(negedge clk);
        check("mr_e_after", {31'd0, e8}, 32'd0);
        check("mr_drive", {31'd0, dut8.bus_drive}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        xfer(1'b0, 1'b1, 2'b10, 8'h5A, 8'h00);
        check("mr_w_done", r_done, 17);
        check("mr_w_data", r_bad, 0);
        check("mr_w_drv", r_drv, 16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
